// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding,
// instruction width and fetch FSM state encoding.
package fetch_stage_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble/flush beats stall,
// stall beats capture.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ADDR_BUS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bubble,
   input  logic                flush,
   input  logic                stall,
   input  logic [WIDTH-1:0]    instr_in,
   input  logic [ADDR_BUS-1:0] pc_in,
   input  logic [ADDR_BUS-1:0] pc_plus4_in,
   output logic [WIDTH-1:0]    instr_d,
   output logic [ADDR_BUS-1:0] pc_d,
   output logic [ADDR_BUS-1:0] pc_plus4_d,
   output logic                valid_d
);

   // Load a NOP bubble, hold, or capture the fetched word.
   always_ff @(posedge clk) begin
      if (rst || bubble || flush) begin
         instr_d    <= WIDTH'(NOP);
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (!stall) begin
         instr_d    <= instr_in;
         pc_d       <= pc_in;
         pc_plus4_d <= pc_plus4_in;
         valid_d    <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection,
// boot FSM and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                  WIDTH    = 32,
   parameter int                  ADDR_BUS = 32,
   parameter logic [ADDR_BUS-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_f,
   input  logic                flush_d,
   input  logic                redirect,
   input  logic [ADDR_BUS-1:0] redirect_target,
   output logic [ADDR_BUS-1:0] imem_addr,
   input  logic [WIDTH-1:0]    imem_rd,
   output logic [WIDTH-1:0]    instr_d,
   output logic [ADDR_BUS-1:0] pc_d,
   output logic [ADDR_BUS-1:0] pc_plus4_d,
   output logic                valid_d,
   output logic                misalign_err
);

   fetch_state_e        state, state_nxt;
   logic [ADDR_BUS-1:0] pc, pc_nxt, pc_plus4;
   logic                misalign_nxt;
   logic                boot;

   assign pc_plus4  = pc + ADDR_BUS'(4);
   assign imem_addr = pc;

   // State, PC and sticky misalign flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         misalign_err <= misalign_nxt;
      end
   end

   // Next state and next PC: redirect > stall > PC+4.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      misalign_nxt = misalign_err;
      boot         = 1'b0;
      unique case (state)
         BOOT: begin
            state_nxt = RUN;
            pc_nxt    = RESET_PC;
            boot      = 1'b1;
         end
         RUN: begin
            if (redirect) begin
               pc_nxt = {redirect_target[ADDR_BUS-1:2], 2'b00};
               if (|redirect_target[1:0])
                  misalign_nxt = 1'b1;
            end else if (!stall_f) begin
               pc_nxt = pc_plus4;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   if_id_reg #(
      .WIDTH    (WIDTH),
      .ADDR_BUS (ADDR_BUS)
   ) u_if_id (
      .clk         (clk),
      .rst         (rst),
      .bubble      (boot),
      .flush       (flush_d),
      .stall       (stall_f),
      .instr_in    (imem_rd),
      .pc_in       (pc),
      .pc_plus4_in (pc_plus4),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc_plus4_d  (pc_plus4_d),
      .valid_d     (valid_d)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot bubble,
// stall, flush, redirect, misalign, wrap, reset.
module tb_fetch_stage;

   localparam logic [31:0] NOPW = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f;
   logic        flush_d;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rd = 32'hA000_0000 | imem_addr;

   fetch_stage #(
      .WIDTH    (32),
      .ADDR_BUS (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_f         (stall_f),
      .flush_d         (flush_d),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rd         (imem_rd),
      .instr_d         (instr_d),
      .pc_d            (pc_d),
      .pc_plus4_d      (pc_plus4_d),
      .valid_d         (valid_d),
      .misalign_err    (misalign_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_if(input string tag,
                         input logic [31:0] epc,
                         input logic [31:0] einstr,
                         input logic        evalid);
      chk({tag, " pc_d"}, pc_d, epc);
      chk({tag, " instr_d"}, instr_d, einstr);
      chk({tag, " valid_d"}, {31'b0, valid_d}, {31'b0, evalid});
   endtask

   initial begin
      rst = 1'b1;
      stall_f = 1'b0;
      flush_d = 1'b0;
      redirect = 1'b0;
      redirect_target = '0;
      tick();
      tick();
      chk("rst addr", imem_addr, 32'h0);
      chk_if("rst", 32'h0, NOPW, 1'b0);
      chk("rst p4", pc_plus4_d, 32'h0);
      chk("rst mis", {31'b0, misalign_err}, 32'h0);

      rst = 1'b0;
      tick();
      chk("boot addr", imem_addr, 32'h0);
      chk_if("boot", 32'h0, NOPW, 1'b0);

      tick();
      chk_if("f0", 32'h0, 32'hA000_0000, 1'b1);
      chk("f0 p4", pc_plus4_d, 32'h4);
      chk("f0 addr", imem_addr, 32'h4);
      tick();
      chk_if("f4", 32'h4, 32'hA000_0004, 1'b1);
      chk("f4 addr", imem_addr, 32'h8);

      stall_f = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall addr", imem_addr, 32'h8);
         chk_if("stall", 32'h4, 32'hA000_0004, 1'b1);
      end
      stall_f = 1'b0;
      tick();
      chk_if("resume", 32'h8, 32'hA000_0008, 1'b1);
      chk("resume addr", imem_addr, 32'hC);

      redirect = 1'b1;
      redirect_target = 32'h40;
      flush_d = 1'b1;
      tick();
      chk("redir addr", imem_addr, 32'h40);
      chk_if("redir flush", 32'h0, NOPW, 1'b0);
      redirect = 1'b0;
      flush_d = 1'b0;
      tick();
      chk_if("redir tgt", 32'h40, 32'hA000_0040, 1'b1);
      chk("redir tgt p4", pc_plus4_d, 32'h44);

      redirect = 1'b1;
      redirect_target = 32'h43;
      tick();
      chk("mis addr", imem_addr, 32'h40);
      chk("mis flag", {31'b0, misalign_err}, 32'h1);
      chk_if("mis cap", 32'h44, 32'hA000_0044, 1'b1);
      redirect = 1'b0;
      tick();
      chk("mis hold", {31'b0, misalign_err}, 32'h1);
      chk_if("mis next", 32'h40, 32'hA000_0040, 1'b1);

      redirect = 1'b1;
      redirect_target = 32'h80;
      stall_f = 1'b1;
      tick();
      chk("rs addr", imem_addr, 32'h80);
      chk_if("rs hold", 32'h40, 32'hA000_0040, 1'b1);
      redirect = 1'b0;
      stall_f = 1'b0;
      tick();
      chk_if("rs after", 32'h80, 32'hA000_0080, 1'b1);
      chk("rs after addr", imem_addr, 32'h84);

      flush_d = 1'b1;
      stall_f = 1'b1;
      tick();
      chk_if("fs", 32'h0, NOPW, 1'b0);
      chk("fs addr", imem_addr, 32'h84);
      flush_d = 1'b0;
      stall_f = 1'b0;
      tick();
      chk_if("fs after", 32'h84, 32'hA000_0084, 1'b1);

      redirect = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      chk("wrap top", imem_addr, 32'hFFFF_FFFC);
      redirect = 1'b0;
      tick();
      chk("wrap addr", imem_addr, 32'h0);
      chk_if("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
      chk("wrap p4", pc_plus4_d, 32'h0);
      chk("wrap mis", {31'b0, misalign_err}, 32'h1);

      rst = 1'b1;
      stall_f = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h100;
      tick();
      chk("rst2 addr", imem_addr, 32'h0);
      chk_if("rst2", 32'h0, NOPW, 1'b0);
      chk("rst2 mis", {31'b0, misalign_err}, 32'h0);
      rst = 1'b0;
      stall_f = 1'b0;
      redirect = 1'b0;
      tick();
      chk_if("boot2", 32'h0, NOPW, 1'b0);
      chk("boot2 addr", imem_addr, 32'h0);
      tick();
      chk_if("boot2 f0", 32'h0, 32'hA000_0000, 1'b1);
      chk("boot2 f0 addr", imem_addr, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
